unified_mem_arbiter: RTL and testbench

UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

---
 rtl/unified_mem_arbiter.sv | 117 +++++++++++
 tb/tb_unified_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single memory port.
// Data normally wins conflicts; a streak counter forces a fetch grant after MAX_DATA_STREAK data wins.
module unified_mem_arbiter #(
  parameter int MAX_DATA_STREAK = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_D, RESP} state_t;

  localparam logic [3:0] STREAK_LIMIT = 4'(MAX_DATA_STREAK);

  state_t     state, state_next;
  logic [3:0] streak;
  logic       grant_d, grant_if, ack_if, ack_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A waiting fetch takes priority over data only once the streak limit is reached.
  always_comb begin
    state_next = state;
    grant_d    = 1'b0;
    grant_if   = 1'b0;
    ack_if     = 1'b0;
    ack_d      = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && !(if_req && streak == STREAK_LIMIT)) begin
          grant_d    = 1'b1;
          state_next = WAIT_D;
        end else if (if_req) begin
          grant_if   = 1'b1;
          state_next = WAIT_IF;
        end
      end
      WAIT_IF: begin
        if (mem_ack) begin
          ack_if     = 1'b1;
          state_next = RESP;
        end
      end
      WAIT_D: begin
        if (mem_ack) begin
          ack_d      = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      streak    <= 4'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_wstrb <= 4'd0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      if_rdata  <= 32'h0000_0013;
      d_rdata   <= 32'd0;
    end else begin
      if_ready <= ack_if;
      d_ready  <= ack_d;
      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_wstrb <= d_wstrb;
        if (if_req && streak < STREAK_LIMIT) streak <= streak + 4'd1;
      end else if (grant_if) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= 32'd0;
        mem_wstrb <= 4'd0;
        streak    <= 4'd0;
      end
      if (ack_if) begin
        mem_req  <= 1'b0;
        if_rdata <= mem_rdata;
      end
      // Stores complete without touching the load-data register.
      if (ack_d) begin
        mem_req <= 1'b0;
        if (!mem_we) d_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed self-checking bench for unified_mem_arbiter with the default streak limit of 2.
module tb_unified_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int compared;
  int mismatched;

  unified_mem_arbiter dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic ifr, input logic [31:0] ifa, input logic dr,
                               input logic we, input logic [31:0] da, input logic [31:0] wd,
                               input logic [3:0] ws);
    if_req  = ifr;
    if_addr = ifa;
    d_req   = dr;
    d_we    = we;
    d_addr  = da;
    d_wdata = wd;
    d_wstrb = ws;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_mem_req"},  32'(mem_req),  32'd0);
    checkOutput({tag, "_if_ready"}, 32'(if_ready), 32'd0);
    checkOutput({tag, "_d_ready"},  32'(d_ready),  32'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkIdleOutputs(tag);
    checkOutput({tag, "_mem_we"},    32'(mem_we),    32'd0);
    checkOutput({tag, "_mem_addr"},  mem_addr,       32'd0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata,      32'd0);
    checkOutput({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
    checkOutput({tag, "_if_rdata"},  if_rdata,       32'h0000_0013);
    checkOutput({tag, "_d_rdata"},   d_rdata,        32'd0);
  endtask

  initial begin
    logic [31:0] fetch_addr;
    logic [31:0] last_d;
    logic        exp_d;

    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    mem_ack    = 1'b0;
    mem_rdata  = 32'd0;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    step();
    step();
    checkResetValues("reset");
    reset = 1'b0;

    // Lone fetch, ack two cycles after mem_req rises
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    step();
    checkOutput("fetch_mem_req",   32'(mem_req),   32'd1);
    checkOutput("fetch_mem_addr",  mem_addr,       32'h10);
    checkOutput("fetch_mem_we",    32'(mem_we),    32'd0);
    checkOutput("fetch_mem_wstrb", 32'(mem_wstrb), 32'd0);
    step();
    checkOutput("fetch_mem_req_hold", 32'(mem_req), 32'd1);
    checkOutput("fetch_no_ready",     32'(if_ready), 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0050_0093;
    step();
    mem_ack = 1'b0;
    checkOutput("fetch_if_ready", 32'(if_ready), 32'd1);
    checkOutput("fetch_if_rdata", if_rdata,      32'h0050_0093);
    checkOutput("fetch_d_ready",  32'(d_ready),  32'd0);
    checkOutput("fetch_mem_drop", 32'(mem_req),  32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    step();
    checkIdleOutputs("fetch_done");
    checkOutput("fetch_if_rdata_hold", if_rdata, 32'h0050_0093);

    // Conflict with streak at 0: load first, then fetch
    applyStimulus(1'b1, 32'h14, 1'b1, 1'b0, 32'h100, 32'd0, 4'd0);
    step();
    checkOutput("conf_grant1_addr", mem_addr,    32'h100);
    checkOutput("conf_grant1_we",   32'(mem_we), 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE_0001;
    step();
    mem_ack = 1'b0;
    checkOutput("conf_d_ready",  32'(d_ready),  32'd1);
    checkOutput("conf_if_ready", 32'(if_ready), 32'd0);
    checkOutput("conf_d_rdata",  d_rdata,       32'hCAFE_0001);
    d_req = 1'b0;
    step();
    checkIdleOutputs("conf_idle");
    step();
    checkOutput("conf_grant2_addr", mem_addr,     32'h14);
    checkOutput("conf_grant2_req",  32'(mem_req), 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0033;
    step();
    mem_ack = 1'b0;
    checkOutput("conf_if_ready2", 32'(if_ready), 32'd1);
    checkOutput("conf_if_rdata2", if_rdata,      32'h0000_0033);
    checkOutput("conf_d_hold",    d_rdata,       32'hCAFE_0001);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    step();

    // Starvation guard: fetch held, data re-requested after each completion
    fetch_addr = 32'h20;
    last_d     = 32'd0;
    applyStimulus(1'b1, fetch_addr, 1'b1, 1'b0, 32'h300, 32'd0, 4'd0);
    for (int g = 0; g < 6; g++) begin
      exp_d = (g % 3 != 2);
      step();
      checkOutput($sformatf("starve_grant%0d", g), mem_addr, exp_d ? 32'h300 : fetch_addr);
      mem_ack   = 1'b1;
      mem_rdata = 32'h1000 + 32'(g);
      step();
      mem_ack = 1'b0;
      checkOutput($sformatf("starve_d_ready%0d", g),  32'(d_ready),  32'(exp_d));
      checkOutput($sformatf("starve_if_ready%0d", g), 32'(if_ready), 32'(!exp_d));
      if (exp_d) begin
        last_d = 32'h1000 + 32'(g);
        checkOutput($sformatf("starve_d_rdata%0d", g), d_rdata, last_d);
        d_req = 1'b0;
      end else begin
        fetch_addr = fetch_addr + 32'd4;
        if_addr    = fetch_addr;
      end
      step();
      d_req = 1'b1;
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    step();

    // Halfword store: d_rdata must keep the last load value
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h200, 32'h0000_BEEF, 4'b0011);
    step();
    checkOutput("store_mem_we",    32'(mem_we),    32'd1);
    checkOutput("store_mem_addr",  mem_addr,       32'h200);
    checkOutput("store_mem_wdata", mem_wdata,      32'h0000_BEEF);
    checkOutput("store_mem_wstrb", 32'(mem_wstrb), 32'b0011);
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_DEAD;
    step();
    mem_ack = 1'b0;
    checkOutput("store_d_ready", 32'(d_ready), 32'd1);
    checkOutput("store_d_rdata", d_rdata,      last_d);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    step();
    checkIdleOutputs("store_done");

    // Reset while waiting for a load, then a stale ack after release
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h400, 32'd0, 4'd0);
    step();
    checkOutput("rst_wait_req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    step();
    checkResetValues("rst_mid");
    reset     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    step();
    mem_ack = 1'b0;
    checkIdleOutputs("rst_stale_ack");
    checkOutput("rst_stale_d_rdata", d_rdata, 32'd0);
    step();
    checkIdleOutputs("rst_stale_after");
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    step();
    checkOutput("rst_regrant_req",  32'(mem_req), 32'd1);
    checkOutput("rst_regrant_addr", mem_addr,     32'h40);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0063;
    step();
    mem_ack = 1'b0;
    checkOutput("rst_regrant_ready", 32'(if_ready), 32'd1);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    step();

    // Spurious ack in IDLE
    mem_ack   = 1'b1;
    mem_rdata = 32'h7777_7777;
    step();
    mem_ack = 1'b0;
    checkIdleOutputs("spurious");
    checkOutput("spurious_if_rdata", if_rdata, 32'h0000_0063);
    step();
    checkIdleOutputs("spurious_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
